// File: rtl/iter_shift_pkg.sv
// iter_shift_pkg: shared definitions for the iterative shifter.
//   Width      - datapath width (8)
//   Op*        - 3-bit operation codes
//   state_e    - controller state encoding
//   is_rotate  - true for the rotate op codes
//   step_count - number of one-bit steps an operation needs
package iter_shift_pkg;

  localparam int unsigned Width = 8;
  localparam int unsigned CountWidth = 4;

  localparam logic [2:0] OpSrl  = 3'b000;
  localparam logic [2:0] OpSll  = 3'b001;
  localparam logic [2:0] OpSra  = 3'b010;
  localparam logic [2:0] OpSll2 = 3'b011;
  localparam logic [2:0] OpRor  = 3'b100;
  localparam logic [2:0] OpRol  = 3'b101;
  localparam logic [2:0] OpRol2 = 3'b110;
  localparam logic [2:0] OpRol3 = 3'b111;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  function automatic logic is_rotate(input logic [2:0] op);
    return op[2];
  endfunction

  // Shifts saturate at Width steps (further steps would not change the result);
  // rotates wrap modulo Width.
  function automatic logic [CountWidth-1:0] step_count(input logic [2:0] op,
                                                       input logic [Width-1:0] amt);
    logic [CountWidth-1:0] n;
    if (is_rotate(op)) begin
      n = {1'b0, amt[2:0]};
    end else if (amt >= Width[Width-1:0]) begin
      n = Width[CountWidth-1:0];
    end else begin
      n = amt[CountWidth-1:0];
    end
    return n;
  endfunction

endpackage

// File: rtl/shift_step.sv
// shift_step: combinational one-bit-position move of a value.
//   value      - current value
//   op         - operation code (iter_shift_pkg::Op*)
//   next_value - value moved by exactly one bit position
module shift_step
  import iter_shift_pkg::*;
(
  input  logic [Width-1:0] value,
  input  logic [2:0]       op,
  output logic [Width-1:0] next_value
);

  always_comb begin
    next_value = value;
    unique case (op)
      OpSrl:         next_value = {1'b0, value[Width-1:1]};
      OpSll, OpSll2: next_value = {value[Width-2:0], 1'b0};
      OpSra:         next_value = {value[Width-1], value[Width-1:1]};
      OpRor:         next_value = {value[0], value[Width-1:1]};
      OpRol, OpRol2, OpRol3: next_value = {value[Width-2:0], value[Width-1]};
      default:       next_value = value;
    endcase
  end

endmodule

// File: rtl/iter_shift.sv
// iter_shift: iterative shifter/rotator, one bit position per clock.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   start - request, accepted in IDLE or DONE only
//   i     - operand, captured on accepted start
//   f     - op code, captured on accepted start
//   s     - shift amount, captured on accepted start
//   o     - result register, held until the next accepted start
//   busy  - high while shifting
//   done  - one-cycle pulse, o valid
module iter_shift
  import iter_shift_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [Width-1:0] i,
  input  logic [2:0]       f,
  input  logic [Width-1:0] s,
  output logic [Width-1:0] o,
  output logic             busy,
  output logic             done
);

  state_e                state_q, state_d;
  logic [Width-1:0]      o_q, o_d;
  logic [2:0]            op_q, op_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic [CountWidth-1:0] start_count;
  logic [Width-1:0]      stepped;

  shift_step u_shift_step (
    .value      (o_q),
    .op         (op_q),
    .next_value (stepped)
  );

  assign start_count = step_count(f, s);

  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    op_d    = op_q;
    count_d = count_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          o_d     = i;
          op_d    = f;
          count_d = start_count;
          state_d = (start_count == '0) ? StDone : StShift;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StShift: begin
        o_d = stepped;
        // count is at least 1 in SHIFT; the guard just keeps it from wrapping.
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end
        if (count_q <= 4'd1) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      o_q     <= '0;
      op_q    <= OpSrl;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      op_q    <= op_d;
      count_q <= count_d;
    end
  end

  assign o    = o_q;
  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);

endmodule

// File: doc/iter_shift.md
ITER_SHIFT -- requirements
Module: iter_shift

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request; sampled only when the block is accepting (REQ-013).
REQ-005 i  input  8  operand, captured on an accepted start.
REQ-006 f  input  3  operation code, captured on an accepted start.
REQ-007 s  input  8  shift amount, captured on an accepted start.
REQ-008 o  output  8  result register; holds its value until the next accepted start.
REQ-009 busy  output  1  high while in state SHIFT.
REQ-010 done  output  1  one-cycle pulse marking o valid.

Function
REQ-011 Op codes SHALL be decoded as follows:
- 000 logical right, zero fill.
- 001 logical left, zero fill.
- 010 arithmetic right, sign fill.
- 011 logical left, zero fill (same as 001).
- 100 rotate right.
- 101 rotate left.
- 110 and 111 rotate left.
REQ-012 States SHALL be IDLE, SHIFT and DONE; the encodings live in the package.
REQ-013 An accepted start SHALL be start=1 in state IDLE or DONE; start in SHIFT SHALL be ignored, and no state changes.
REQ-014 On an accepted start, the block SHALL load o<=i, latch the op and set count<=N.
REQ-015 N SHALL be computed as follows:
- Shift codes: N = min(s,8).
- Rotate codes: N = s[2:0].
REQ-016 If N=0, the next state SHALL be DONE, so done asserts 1 cycle after start with o=i.
REQ-017 If N>0, the next state SHALL be SHIFT.
REQ-018 In each SHIFT cycle, o SHALL move exactly one bit position per the latched op and count SHALL decrement by 1.
REQ-019 SHIFT SHALL go to DONE on the cycle where count reaches 0, so done asserts exactly N+1 cycles after the accepting edge.
REQ-020 DONE SHALL last one cycle, then go to IDLE, unless a new start is accepted in that cycle, in which case it goes to SHIFT or DONE per REQ-016/017.
REQ-021 Saturation SHALL behave as follows:
- s>=8 on logical ops yields 0x00.
- s>=8 on arithmetic right yields 0x00 or 0xFF by i[7].
- Rotates SHALL wrap modulo 8.
REQ-022 The count register SHALL be 4 bits wide; no wrap below 0 is permitted.
REQ-023 Changes to i, f or s after the accepted start SHALL NOT affect the operation in flight.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, o=0x00, count=0, busy=0 and done=0.
REQ-025 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse.
REQ-026 After reset release, the first rising edge SHALL accept start.

Structure
REQ-027 The shared package SHALL hold the 3-bit op-code constants, the state encoding and the data width (8).
REQ-028 The one-bit step datapath SHALL be a combinational sub-module shift_step, with inputs value and op and output next value, instantiated once.
REQ-029 Output and state registers SHALL sit in iter_shift; o SHALL be a direct register output.

Verification
REQ-030 Shift right: i=0xB4, f=000, s=3 -> busy for 3 cycles, done 4 cycles after start, o=0x16.
REQ-031 Arithmetic right: i=0xB4, f=010, s=3 -> o=0xF6; same input with s=20 -> o=0xFF with done after 9 cycles.
REQ-032 Rotates and zero amount:
- i=0x81, f=101, s=9 -> o=0x03 after 2 cycles.
- i=0x81, f=100, s=0 -> done 1 cycle after start, o=0x81.
REQ-033 Start while busy: i=0x0F, f=001, s=4, with a second start (i=0xFF) pulsed mid-SHIFT -> ignored, o=0xF0.
REQ-034 Back-to-back start in the DONE cycle is accepted with no idle gap. Reset asserted at SHIFT cycle 2 -> o=0x00, no done; the next start completes normally.
